// File: rtl/serial_inst_mem.sv
// Memory-side responder for the bit-serial fetch protocol.
// Shifts a word address in, then streams the addressed word back MSB first.
module serial_inst_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  addr_valid,
    input  logic                  addr_in,
    output logic                  data_out,
    output logic                  data_valid,
    output logic                  busy,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  proto_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [5:0] A_LAST = 6'(ADDR_WIDTH - 1);
    localparam logic [5:0] D_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE =
        DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    state_t                  state, state_d;
    logic [5:0]              bit_cnt, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_sr, addr_d, addr_shift;
    logic                    err_d;
    logic                    in_range, prog_ok;
    logic [DATA_WIDTH-1:0]   word, mask;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign addr_shift = (addr_sr << 1) | ADDR_WIDTH'(addr_in);
    assign in_range   = {1'b0, addr_sr} < (ADDR_WIDTH+1)'(DEPTH);
    assign prog_ok    = {1'b0, prog_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign word       = in_range ? mem[addr_sr] : '0;
    assign mask       = MSB_ONE >> bit_cnt;

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge sys_clk) begin
        if (prog_we && state == IDLE && prog_ok)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            addr_sr   <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= cnt_d;
            addr_sr   <= addr_d;
            proto_err <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt;
        addr_d  = addr_sr;
        err_d   = proto_err;
        unique case (state)
            IDLE: begin
                if (addr_valid) begin
                    addr_d = addr_shift;
                    if (ADDR_WIDTH == 1) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = ADDR;
                        cnt_d   = 6'd1;
                    end
                end
            end
            ADDR: begin
                if (prog_we)
                    err_d = 1'b1;
                if (!addr_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_shift;
                    if (bit_cnt == A_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = bit_cnt + 6'd1;
                    end
                end
            end
            DATA: begin
                if (addr_valid || prog_we || !in_range)
                    err_d = 1'b1;
                if (bit_cnt == D_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = bit_cnt + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_valid = (state == DATA);
        busy       = (state != IDLE);
        data_out   = data_valid & (|(word & mask));
    end

endmodule

// File: tb/tb_serial_inst_mem.sv
// Scoreboard bench for serial_inst_mem: 8/16 instruction and 9/24 micro
// instances, expected bits tagged with the cycle they must appear in.
module tb_serial_inst_mem;

    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    logic        sys_clk;
    logic        sys_reset;
    int          cyc = 0;
    int          n_tot = 0;
    int          n_pass = 0;

    logic        av8, ai8, do8, dv8, bz8, we8, pe8;
    logic [7:0]  pa8;
    logic [15:0] pd8;
    logic        av9, ai9, do9, dv9, bz9, we9, pe9;
    logic [8:0]  pa9;
    logic [23:0] pd9;

    exp_t        q8[$];
    exp_t        q9[$];
    logic [15:0] m8 [int];
    logic [23:0] m9 [int];

    serial_inst_mem u8 (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .addr_valid (av8),
        .addr_in    (ai8),
        .data_out   (do8),
        .data_valid (dv8),
        .busy       (bz8),
        .prog_we    (we8),
        .prog_addr  (pa8),
        .prog_data  (pd8),
        .proto_err  (pe8)
    );

    serial_inst_mem #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (24)
    ) u9 (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .addr_valid (av9),
        .addr_in    (ai9),
        .data_out   (do9),
        .data_valid (dv9),
        .busy       (bz9),
        .prog_we    (we9),
        .prog_addr  (pa9),
        .prog_data  (pd9),
        .proto_err  (pe9)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (dv8) begin
            if (q8.size() == 0) begin
                chk("unexpected_valid8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("cycle8", cyc, e.cyc);
                chk("bit8", do8, e.b);
            end
        end else begin
            chk("idle_dout8", do8, 0);
        end
        if (dv9) begin
            if (q9.size() == 0) begin
                chk("unexpected_valid9", 1, 0);
            end else begin
                e = q9.pop_front();
                chk("cycle9", cyc, e.cyc);
                chk("bit9", do9, e.b);
            end
        end else begin
            chk("idle_dout9", do9, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic prog(input bit micro, input int a, input logic [23:0] d);
        if (micro) begin
            we9 = 1'b1; pa9 = 9'(a); pd9 = d; m9[a] = d;
        end else begin
            we8 = 1'b1; pa8 = 8'(a); pd8 = d[15:0]; m8[a] = d[15:0];
        end
        tick(1);
        we8 = 1'b0;
        we9 = 1'b0;
    endtask

    task automatic req(input bit micro, input int a);
        int          aw;
        int          dw;
        int          t0;
        logic [23:0] w;
        exp_t        e;
        aw = micro ? 9 : 8;
        dw = micro ? 24 : 16;
        t0 = cyc;
        w  = micro ? m9[a] : {8'h00, m8[a]};
        for (int k = 0; k < dw; k++) begin
            e.cyc = t0 + aw + k;
            e.b   = w[dw-1-k];
            if (micro) q9.push_back(e);
            else q8.push_back(e);
        end
        for (int i = 0; i < aw; i++) begin
            if (micro) begin
                av9 = 1'b1; ai9 = a[aw-1-i];
            end else begin
                av8 = 1'b1; ai8 = a[aw-1-i];
            end
            tick(1);
        end
        av8 = 1'b0; ai8 = 1'b0;
        av9 = 1'b0; ai9 = 1'b0;
    endtask

    initial begin
        av8 = 0; ai8 = 0; we8 = 0; pa8 = '0; pd8 = '0;
        av9 = 0; ai9 = 0; we9 = 0; pa9 = '0; pd9 = '0;
        sys_reset = 1'b0;
        #2;
        chk("rst_busy", bz8, 0);
        chk("rst_valid", dv8, 0);
        chk("rst_dout", do8, 0);
        chk("rst_err", pe8, 0);
        tick(1);
        sys_reset = 1'b1;
        tick(1);

        prog(0, 'hA5, 24'hBEEF);
        prog(0, 'h00, 24'h1234);

        // basic fetch
        req(0, 'hA5);
        tick(16);
        chk("basic_err", pe8, 0);
        chk("basic_busy_after", bz8, 0);

        // back-to-back
        req(0, 'hA5);
        tick(16);
        req(0, 'h00);
        tick(16);
        chk("b2b_err", pe8, 0);

        // abort after three bits
        av8 = 1; ai8 = 1; tick(1);
        chk("abort_busy_mid", bz8, 1);
        ai8 = 0; tick(1);
        ai8 = 1; tick(1);
        av8 = 0; ai8 = 0; tick(1);
        chk("abort_busy", bz8, 0);
        tick(20);
        chk("abort_err", pe8, 0);
        req(0, 'hA5);
        tick(16);

        // illegal write during DATA
        req(0, 'hA5);
        tick(2);
        we8 = 1; pa8 = 8'hA5; pd8 = 16'h0000;
        chk("illegal_err_before", pe8, 0);
        tick(1);
        we8 = 0;
        chk("illegal_err_after", pe8, 1);
        tick(13);
        req(0, 'hA5);
        tick(16);
        chk("illegal_err_sticky", pe8, 1);

        // asynchronous reset mid-DATA
        req(0, 'hA5);
        tick(2);
        chk("pre_rst_dout", do8, 1);
        #2;
        sys_reset = 1'b0;
        q8.delete();
        #1;
        chk("arst_dout", do8, 0);
        chk("arst_valid", dv8, 0);
        chk("arst_busy", bz8, 0);
        chk("arst_err", pe8, 0);
        tick(1);
        sys_reset = 1'b1;
        tick(1);
        req(0, 'hA5);
        tick(16);
        chk("post_rst_err", pe8, 0);

        // micro-instruction instance
        prog(1, 'h1FF, 24'hAAAAAA);
        req(1, 'h1FF);
        tick(24);
        chk("micro_err", pe9, 0);
        chk("micro_busy", bz9, 0);

        tick(2);
        chk("q8_drained", q8.size(), 0);
        chk("q9_drained", q9.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
